// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// master: fetch stage (issues requests, consumes responses).
// slave : instruction memory.
interface if_fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, credit-limited in-order imem requests,
// response FIFO with bypass, and the IF/ID register feeding decode.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect targets halt fetch
// and present a single flagged entry on id_misalign_o.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_fetch_stage_if.master imem,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
`ifdef FETCH_MISALIGN_EN
  output logic        id_misalign_o,
`endif
  output logic [6:0]  id_op_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [31:0]      fifo_pc_q    [DEPTH];
  logic [31:0]      fifo_instr_q [DEPTH];
  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [31:0]      id_pc_q, id_pc_d;

  logic             fetch_en_c;
  logic             credit_ok_c;
  logic             req_c;
  logic             grant_c;
  logic             rsp_c;
  logic             keep_c;
  logic             load_en_c;
  logic             push_c;
  logic             pop_c;
  logic             flush_c;
  logic [31:0]      target_c;

`ifdef FETCH_MISALIGN_EN
  logic             halt_q, halt_d;
  logic             misalign_q, misalign_d;
  logic             tgt_misaligned_c;

  assign fetch_en_c       = ~halt_q;
  assign tgt_misaligned_c = |redirect_pc_i[1:0];
  assign target_c         = tgt_misaligned_c ? redirect_pc_i : {redirect_pc_i[31:2], 2'b00};
  assign id_misalign_o    = misalign_q;
`else
  logic             unused_c;

  assign fetch_en_c = 1'b1;
  assign target_c   = {redirect_pc_i[31:2], 2'b00};
  assign unused_c   = ^redirect_pc_i[1:0];
`endif

  // Request only while credits remain (in-flight + buffered words < DEPTH).
  assign credit_ok_c = (SUM_W'(out_q) + SUM_W'(cnt_q)) < SUM_W'(DEPTH);
  assign req_c       = rst_i & ~redirect_i & credit_ok_c & fetch_en_c;
  assign grant_c     = req_c & imem.imem_gnt_i;
  assign rsp_c       = imem.imem_rvalid_i & (out_q != '0);
  assign keep_c      = rsp_c & (drop_q == '0);
  assign load_en_c   = ~stall_i | ~id_valid_q;

  assign imem.imem_req_o  = req_c;
  assign imem.imem_addr_o = pc_q;

  assign id_valid_o = id_valid_q;
  assign id_instr_o = id_instr_q;
  assign id_pc_o    = id_pc_q;
  assign id_op_o    = id_instr_q[6:0];

  // Next-state for PC, credit/drop counters and IF/ID register.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    flush_c    = 1'b0;
`ifdef FETCH_MISALIGN_EN
    halt_d     = halt_q;
    misalign_d = misalign_q;
`endif

    unique case ({grant_c, rsp_c})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase

    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d       = target_c;
      rsp_pc_d   = target_c;
      drop_d     = out_d;
      flush_c    = 1'b1;
      id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
      halt_d     = tgt_misaligned_c;
      misalign_d = 1'b0;
      if (tgt_misaligned_c) begin
        id_valid_d = 1'b1;
        misalign_d = 1'b1;
        id_pc_d    = redirect_pc_i;
        id_instr_d = NOP;
      end
`endif
    end else begin
      if (grant_c) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_c && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (keep_c) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end

      if (load_en_c) begin
`ifdef FETCH_MISALIGN_EN
        misalign_d = 1'b0;
`endif
        if (cnt_q != '0) begin
          id_valid_d = 1'b1;
          id_instr_d = fifo_instr_q[rd_q];
          id_pc_d    = fifo_pc_q[rd_q];
          pop_c      = 1'b1;
          push_c     = keep_c;
        end else if (keep_c) begin
          // Bypass: fresh response goes straight to IF/ID.
          id_valid_d = 1'b1;
          id_instr_d = imem.imem_rdata_i;
          id_pc_d    = rsp_pc_q;
        end else begin
          id_valid_d = 1'b0;
        end
      end else begin
        push_c = keep_c;
      end
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_c) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + PTR_W'(push_c);
      rd_d  = rd_q + PTR_W'(pop_c);
      cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // FIFO storage; contents are don't-care when the entry is not counted.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      fifo_pc_q[wr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_q] <= imem.imem_rdata_i;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q       <= PC_RESET;
      rsp_pc_q   <= PC_RESET;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP;
      id_pc_q    <= '0;
`ifdef FETCH_MISALIGN_EN
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
`ifdef FETCH_MISALIGN_EN
      halt_q     <= halt_d;
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a queue-based fetch model.
module tb_if_fetch_stage;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_op;

  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .imem         (bus),
    .redirect_i   (redir),
    .redirect_pc_i(rpc),
    .stall_i      (stall),
    .id_valid_o   (id_valid),
    .id_instr_o   (id_instr),
    .id_pc_o      (id_pc),
    .id_op_o      (id_op)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  // Reference model: in-flight fetch tags, buffered words, IF/ID contents.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } inf_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  inf_t        inf_q[$];
  logic [31:0] buf_q[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  logic        m_idv;
  logic [31:0] m_ipc;
  logic [31:0] m_iinstr;

  int cyc      = 0;
  int last_due = 0;
  bit hold_gnt = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  int rv_pct   = 100;

  task automatic step(input logic r, input logic s, input logic d,
                      input logic [31:0] t, input logic g);
    logic  rv;
    logic  exp_req;
    logic  gnt_eff;
    logic  have_new;
    logic [31:0] new_pc;
    inf_t  e;
    mreq_t mr;
    int    lat;
    @(negedge clk);
    gnt_eff = g & ~hold_gnt;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    rst_n = r;
    stall = s;
    redir = d;
    rpc   = t;
    bus.imem_gnt_i    = gnt_eff;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? mem_f(mem_q[0].addr) : $urandom;
    #1;
    exp_req = r && !d && ((inf_q.size() + buf_q.size()) < DEPTH);
    chk("req",      32'(bus.imem_req_o), 32'(exp_req));
    chk("addr",     bus.imem_addr_o, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_idv));
    chk("id_pc",    id_pc, m_ipc);
    chk("id_instr", id_instr, m_iinstr);
    chk("id_op",    32'(id_op), 32'(m_iinstr[6:0]));

    // Memory environment reacts to the actual bus.
    if (rv) void'(mem_q.pop_front());
    if (bus.imem_req_o && gnt_eff) begin
      lat     = $urandom_range(lat_max, lat_min);
      mr.addr = bus.imem_addr_o;
      mr.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = mr.due;
      mem_q.push_back(mr);
    end

    // Model update for this clock edge.
    if (!r) begin
      m_pc     = PC_RESET;
      m_idv    = 1'b0;
      m_iinstr = NOP;
      m_ipc    = '0;
      inf_q.delete();
      buf_q.delete();
      hold_gnt = 1;
    end else begin
      have_new = 1'b0;
      new_pc   = '0;
      if (rv && inf_q.size() > 0) begin
        e = inf_q.pop_front();
        if (!e.stale) begin
          have_new = 1'b1;
          new_pc   = e.pc;
        end
      end
      if (d) begin
        m_pc = {t[31:2], 2'b00};
        for (int i = 0; i < inf_q.size(); i++) begin
          e = inf_q[i];
          e.stale = 1;
          inf_q[i] = e;
        end
        buf_q.delete();
        m_idv = 1'b0;
      end else begin
        if (exp_req && gnt_eff) begin
          e.pc    = m_pc;
          e.stale = 0;
          inf_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
        if (!s || !m_idv) begin
          if (buf_q.size() > 0) begin
            m_ipc    = buf_q.pop_front();
            m_iinstr = mem_f(m_ipc);
            m_idv    = 1'b1;
            if (have_new) buf_q.push_back(new_pc);
          end else if (have_new) begin
            m_ipc    = new_pc;
            m_iinstr = mem_f(new_pc);
            m_idv    = 1'b1;
          end else begin
            m_idv = 1'b0;
          end
        end else if (have_new) begin
          buf_q.push_back(new_pc);
        end
      end
    end
    if (hold_gnt && r && mem_q.size() == 0) hold_gnt = 0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redir = 1'b0;
    rpc   = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    m_pc     = PC_RESET;
    m_idv    = 1'b0;
    m_iinstr = NOP;
    m_ipc    = '0;
    @(posedge clk);
    cyc++;

    // Reset state, then a steady single-cycle-latency stream.
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Three-cycle latency: credits run out, requests throttle.
    lat_min = 3; lat_max = 3;
    repeat (24) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Five-cycle decode stall in a steady stream.
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x100 with requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (15) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect and stall in the same cycle.
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset pulse with requests outstanding; late responses must be ignored.
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (15) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random mix of latency, grant gaps, stalls, redirects and resets.
    lat_min = 1; lat_max = 4; rv_pct = 70;
    repeat (3000) begin
      step(($urandom_range(199) != 0),
           ($urandom_range(3) == 0),
           ($urandom_range(29) == 0),
           $urandom,
           ($urandom_range(2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage directly upstream of the decode/control logic. Holds the PC and issues in-order requests to instruction memory with variable response latency, buffering returned words in a small FIFO. Presents one instruction per cycle in the IF/ID register; id_op_o drives the control unit opcode input. Supports decode-side stall and EX-side redirect (taken branch/JAL).

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, max (in-flight requests + FIFO entries); FIFO holds DEPTH words; power of 2, >=2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address (= PC), bits [1:0] always 00
imem_gnt_i  in  1  request accepted this cycle (only meaningful with imem_req_o)
imem_rvalid_i  in  1  response valid, in request order, >=1 cycle after grant
imem_rdata_i  in  32  response instruction word
redirect_i  in  1  taken branch/jump from EX
redirect_pc_i  in  32  redirect target
stall_i  in  1  decode hazard: hold IF/ID register
id_valid_o  out  1  IF/ID register holds a valid instruction
id_instr_o  out  32  instruction word
id_pc_o  out  32  PC of id_instr_o
id_op_o  out  7  id_instr_o[6:0], to control unit opcode input

Behaviour:
- Reset (rst_i=0 at clock edge): pc<=PC_RESET, outstanding<=0, drop_cnt<=0, FIFO empty, id_valid_o<=0, id_instr_o<=32'h0000_0013 (NOP), id_pc_o<=0. imem_req_o=0 while rst_i=0. Reset mid-transaction abandons all in-flight responses; responses arriving after reset while outstanding=0 are ignored.
- imem_req_o (combinational) = rst_i & ~redirect_i & (outstanding + fifo_count < DEPTH). imem_addr_o = pc.
- Grant: req & gnt -> pc<=pc+4 (wraps mod 2^32), outstanding+1.
- Response: rvalid -> outstanding-1. If drop_cnt>0: discard, drop_cnt-1. Else push {pc_tag, rdata} into FIFO; pc_tag tracked per-request in order. Credit rule guarantees FIFO never overflows. rvalid with outstanding=0: ignored.
- Same-cycle grant and response: outstanding unchanged.
- IF/ID update when ~stall_i | ~id_valid_o: if FIFO non-empty pop head into id_* (id_valid_o<=1); else id_valid_o<=0. A response arriving into an empty FIFO reaches id_* one cycle later (latency grant->id_valid_o = mem latency + 1). When stall_i & id_valid_o: id_* hold.
- Redirect (priority over stall and grant): pc<={redirect_pc_i[31:2],2'b00}; FIFO cleared; id_valid_o<=0; drop_cnt<=outstanding minus 1 if non-dropped... precisely drop_cnt<=outstanding_next (all in-flight after this cycle's response). No request issued in redirect cycle; fetch from target starts next cycle.
- id_op_o always equals id_instr_o[6:0], including when invalid (NOP -> 7'b0010011 only after reset; otherwise stale, qualify with id_valid_o).

Optional Feature:
FETCH_MISALIGN_EN: defined -> adds output id_misalign_o (1 bit); redirect with redirect_pc_i[1:0]!=0 sets pc to the raw target, suppresses all requests, and loads id_* next cycle with id_valid_o=1, id_misalign_o=1, id_pc_o=target, id_instr_o=NOP; fetch stays halted until next redirect or reset. Undefined -> port absent, target bits [1:0] forced to 00.

Test Plan:
- Reset, gnt=1 always, rvalid 1 cycle after grant, mem[i]=i -> id_pc_o 0,4,8,... one per cycle, first id_valid_o 2 cycles after first req, no bubbles.
- Response latency 3 cycles, DEPTH=2 -> at most 2 grants outstanding, imem_req_o drops when credits exhausted, no lost or duplicated instruction.
- stall_i=1 for 5 cycles in steady stream -> id_* held, FIFO fills, imem_req_o=0 when full, resumes in order with no gap in id_pc_o.
- Redirect to 32'h100 with 2 in flight -> both stale responses discarded, next valid id_pc_o=32'h100, id_instr_o=mem[0x100].
- redirect_i and stall_i same cycle -> id_valid_o=0 next cycle, redirect taken.
- rst_i=0 pulse with 2 outstanding -> pc=PC_RESET, late responses ignored, stream restarts at PC_RESET.
